// File: rtl/nco_pkg.sv
// Shared widths, reset tuning word and sample/quadrant types for the quadrature NCO.
package nco_pkg;

    localparam int ACC_W  = 32;
    localparam int OFF_W  = 16;
    localparam int LUT_AW = 8;
    localparam int OUT_W  = 12;
    localparam int ROM_W  = OUT_W - 1;
    localparam int PH_W   = LUT_AW + 2;

    // 0.16 * 2^32: 8 MHz at a 50 MHz clock
    localparam logic [ACC_W-1:0] DEFAULT_FTW = 32'h28F5C28F;

    // Quarter turn expressed in the truncated phase word
    localparam logic [PH_W-1:0] PH_QUARTER = PH_W'(1) << LUT_AW;

    typedef logic signed [OUT_W-1:0] sample_t;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

    // round(2047 * sin(pi * (2k+1) / 1024)), evaluated at elaboration with a
    // Q30 fixed-point Taylor series so the table needs no real arithmetic.
    function automatic logic [ROM_W-1:0] quarter_sine(input int unsigned k);
        localparam longint Q      = 64'sd1073741824;
        localparam longint PI_Q30 = 64'sd3373259426;
        longint x;
        longint term;
        longint sum;
        longint r;
        x    = (longint'(2 * k + 1) * PI_Q30) / 1024;
        term = x;
        sum  = x;
        for (int unsigned n = 1; n < 8; n++) begin
            term = -((((term * x) / Q) * x) / Q) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        r = (sum * 2047 + Q / 2) / Q;
        return ROM_W'(r);
    endfunction

endpackage

// File: rtl/nco_sine_quarter_rom.sv
// Registered 256 x 11 quarter-wave sine ROM with independent sine and cosine read ports.
module nco_sine_quarter_rom
    import nco_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [LUT_AW-1:0] addr_sin,
    input  logic [LUT_AW-1:0] addr_cos,
    output logic [ROM_W-1:0]  data_sin,
    output logic [ROM_W-1:0]  data_cos
);

    logic [ROM_W-1:0] rom [1 << LUT_AW];

    for (genvar k = 0; k < (1 << LUT_AW); k++) begin : g_rom
        localparam logic [ROM_W-1:0] ENTRY = quarter_sine(k);
        assign rom[k] = ENTRY;
    end

    // One-cycle synchronous read on both ports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sin <= '0;
            data_cos <= '0;
        end else begin
            data_sin <= rom[addr_sin];
            data_cos <= rom[addr_cos];
        end
    end

endmodule

// File: rtl/quadrature_ref_nco.sv
// Quadrature NCO: phase accumulator, offset adder, quarter-wave ROM and sign stage.
// ref_sig_q leads ref_sig by a quarter turn.
module quadrature_ref_nco
    import nco_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [ACC_W-1:0] ftw_in,
    input  logic             ftw_load,
    input  logic [OFF_W-1:0] off_in,
    input  logic             off_load,
    input  logic             sync_clear,
    output sample_t          ref_sig,
    output sample_t          ref_sig_q,
    output logic             out_valid,
    output logic             cycle_start
);

    localparam int FRAC_W = OFF_W - PH_W;

    // S0 state
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ftw_reg;
    logic [OFF_W-1:0] off_reg;
    logic [OFF_W-1:0] ph0;
    logic             v0, w0;
    logic [ACC_W:0]   acc_sum;

    // S1 state
    logic [PH_W-1:0]   p_sin, p_cos;
    logic              frac_carry;
    quadrant_t         q1_sin, q1_cos;
    logic [LUT_AW-1:0] a1_sin, a1_cos;
    logic              v1, w1;

    // S2 state
    logic [ROM_W-1:0]  rom_sin, rom_cos;
    quadrant_t         q2_sin, q2_cos;
    logic              v2, w2;

    // Accumulator sum with carry-out used as the wrap flag
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, ftw_reg};
    end

    // S0: tuning/offset registers, accumulator, and the phase it held this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            ftw_reg <= DEFAULT_FTW;
            off_reg <= '0;
            ph0     <= '0;
            v0      <= 1'b0;
            w0      <= 1'b0;
        end else begin
            if (ftw_load) ftw_reg <= ftw_in;
            if (off_load) off_reg <= off_in;
            if (sync_clear) begin
                acc <= '0;
                w0  <= 1'b0;
            end else if (enable) begin
                acc <= acc_sum[ACC_W-1:0];
                w0  <= acc_sum[ACC_W];
            end else begin
                w0  <= 1'b0;
            end
            ph0 <= acc[ACC_W-1 -: OFF_W];
            v0  <= enable | sync_clear;
        end
    end

    // Offset add done only on the kept top bits: the discarded fraction bits
    // contribute solely their carry (a + b >= 2^FRAC_W  <=>  a > ~b).
    always_comb begin
        frac_carry = (ph0[FRAC_W-1:0] > ~off_reg[FRAC_W-1:0]);
        p_sin      = ph0[OFF_W-1 -: PH_W] + off_reg[OFF_W-1 -: PH_W] + PH_W'(frac_carry);
        p_cos      = p_sin + PH_QUARTER;
    end

    // S1: split into quadrant and mirrored ROM address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1_sin <= QUAD_0;
            q1_cos <= QUAD_0;
            a1_sin <= '0;
            a1_cos <= '0;
            v1     <= 1'b0;
            w1     <= 1'b0;
        end else begin
            q1_sin <= quadrant_t'(p_sin[PH_W-1 -: 2]);
            q1_cos <= quadrant_t'(p_cos[PH_W-1 -: 2]);
            a1_sin <= p_sin[LUT_AW] ? ~p_sin[LUT_AW-1:0] : p_sin[LUT_AW-1:0];
            a1_cos <= p_cos[LUT_AW] ? ~p_cos[LUT_AW-1:0] : p_cos[LUT_AW-1:0];
            v1     <= v0;
            w1     <= w0;
        end
    end

    nco_sine_quarter_rom u_rom (
        .clk      (clk),
        .reset    (reset),
        .addr_sin (a1_sin),
        .addr_cos (a1_cos),
        .data_sin (rom_sin),
        .data_cos (rom_cos)
    );

    // S2: quadrant and flags travel alongside the ROM read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q2_sin <= QUAD_0;
            q2_cos <= QUAD_0;
            v2     <= 1'b0;
            w2     <= 1'b0;
        end else begin
            q2_sin <= q1_sin;
            q2_cos <= q1_cos;
            v2     <= v1;
            w2     <= w1;
        end
    end

    // S3: negate the lower half-cycle and register the outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_sig     <= '0;
            ref_sig_q   <= '0;
            out_valid   <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            ref_sig     <= (q2_sin inside {QUAD_2, QUAD_3}) ? -sample_t'({1'b0, rom_sin})
                                                            :  sample_t'({1'b0, rom_sin});
            ref_sig_q   <= (q2_cos inside {QUAD_2, QUAD_3}) ? -sample_t'({1'b0, rom_cos})
                                                            :  sample_t'({1'b0, rom_cos});
            out_valid   <= v2;
            cycle_start <= w2;
        end
    end

endmodule

// File: tb/tb_quadrature_ref_nco.sv
// Scoreboard bench for quadrature_ref_nco: a phase-level model pushes the
// expected sample for every clock edge, a monitor pops one per cycle.
module tb_quadrature_ref_nco;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic [31:0]        ftw_in = '0;
    logic               ftw_load = 1'b0;
    logic [15:0]        off_in = '0;
    logic               off_load = 1'b0;
    logic               sync_clear = 1'b0;
    logic signed [11:0] ref_sig;
    logic signed [11:0] ref_sig_q;
    logic               out_valid;
    logic               cycle_start;

    quadrature_ref_nco dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ftw_in      (ftw_in),
        .ftw_load    (ftw_load),
        .off_in      (off_in),
        .off_load    (off_load),
        .sync_clear  (sync_clear),
        .ref_sig     (ref_sig),
        .ref_sig_q   (ref_sig_q),
        .out_valid   (out_valid),
        .cycle_start (cycle_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [11:0] i;
        logic signed [11:0] q;
        logic               v;
        logic               w;
        logic               chk;
    } exp_t;

    exp_t  sbq[$];
    int    total = 0;
    int    bad   = 0;
    int    cs_seen = 0;
    int    m_wraps = 0;

    logic [31:0] m_acc;
    logic [31:0] m_ftw;
    logic [15:0] m_off;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Sine of a phase word: 1024 steps per turn, sampled mid-step, 2047 full scale
    function automatic logic signed [11:0] ref_sine(input logic [15:0] ph);
        int  idx;
        real ang;
        real v;
        int  r;
        idx = int'(ph[15:6]);
        ang = 2.0 * 3.14159265358979 * (real'(idx) + 0.5) / 1024.0;
        v   = 2047.0 * $sin(ang);
        r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        return 12'(r);
    endfunction

    task automatic model_reset();
        exp_t e;
        m_acc = '0;
        m_ftw = 32'h28F5C28F;
        m_off = '0;
        sbq.delete();
        e.i = '0; e.q = '0; e.v = 1'b0; e.w = 1'b0; e.chk = 1'b0;
        repeat (3) sbq.push_back(e);
    endtask

    // One clock edge of the reference: the sample shown is the phase held before the edge
    task automatic model_step();
        logic [32:0] s;
        logic [15:0] ph;
        logic [31:0] nxt;
        logic        w;
        exp_t        e;
        w  = 1'b0;
        ph = m_acc[31:16];
        if (sync_clear) begin
            nxt = '0;
        end else if (enable) begin
            s   = {1'b0, m_acc} + {1'b0, m_ftw};
            w   = s[32];
            nxt = s[31:0];
        end else begin
            nxt = m_acc;
        end
        if (ftw_load) m_ftw = ftw_in;
        if (off_load) m_off = off_in;
        e.i   = ref_sine(ph + m_off);
        e.q   = ref_sine(ph + m_off + 16'h4000);
        e.v   = enable | sync_clear;
        e.w   = w;
        e.chk = 1'b1;
        sbq.push_back(e);
        m_acc = nxt;
        if (w) m_wraps++;
    endtask

    task automatic step(input logic en, input logic sc, input logic fl, input logic [31:0] fv,
                        input logic ol, input logic [15:0] ov);
        enable     = en;
        sync_clear = sc;
        ftw_load   = fl;
        ftw_in     = fv;
        off_load   = ol;
        off_in     = ov;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n, input logic en);
        for (int k = 0; k < n; k++) step(en, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0; sync_clear = 1'b0; ftw_load = 1'b0; off_load = 1'b0;
        #1;
        chk("reset ref_sig", int'(ref_sig), 0);
        chk("reset ref_sig_q", int'(ref_sig_q), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset cycle_start", int'(cycle_start), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: one expected entry per cycle, popped away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (sbq.size() == 0) begin
                    chk("scoreboard underflow", 0, 1);
                end else begin
                    e = sbq.pop_front();
                    chk("out_valid", int'(out_valid), int'(e.v));
                    chk("cycle_start", int'(cycle_start), int'(e.w));
                    if (e.chk) begin
                        chk("ref_sig", int'(ref_sig), int'(e.i));
                        chk("ref_sig_q", int'(ref_sig_q), int'(e.q));
                        chk("nonzero in-range sample",
                            int'(ref_sig != 0 && ref_sig >= -2047 && ref_sig_q != 0 && ref_sig_q >= -2047), 1);
                    end
                    if (cycle_start) cs_seen++;
                end
            end
        end
    end

    initial begin
        int wr0;
        int cs0;

        do_reset();

        // Default tuning word: first valid sample on the fourth edge is phase zero
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("edge3 out_valid", int'(out_valid), 0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("edge4 out_valid", int'(out_valid), 1);
        chk("edge4 ref_sig", int'(ref_sig), 6);
        chk("edge4 ref_sig_q", int'(ref_sig_q), 2047);
        run(20, 1'b1);

        // Quarter-turn steps, then a 90 degree offset loaded mid-run
        step(1'b1, 1'b0, 1'b1, 32'h4000_0000, 1'b1, 16'h0000);
        run(24, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 16'h4000);
        run(16, 1'b1);

        // Hold the accumulator for 10 cycles, then resume
        run(10, 1'b0);
        run(10, 1'b1);

        // Realignment together with a new tuning word; ftw load while disabled
        step(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, '0);
        run(12, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, '0);
        run(8, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h9000_0001, 1'b0, '0);
        run(12, 1'b1);

        // Reset mid-run clears outputs immediately
        do_reset();

        // Default tuning word for 6250 enabled cycles: count wrap pulses
        wr0 = m_wraps;
        cs0 = cs_seen;
        run(6250, 1'b1);
        run(3, 1'b0);
        @(negedge clk);
        #1;
        chk("wrap pulse count", cs_seen - cs0, m_wraps - wr0);

        // Randomised mix of enables, realignments and register loads
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 7) != 0,
                 $urandom_range(0, 22) == 0,
                 $urandom_range(0, 16) == 0, $urandom,
                 $urandom_range(0, 18) == 0, 16'($urandom));
        end
        run(4, 1'b1);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
